// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and round-robin pick helper for the UART MMIO arbiter
package uart_pkg;

    typedef enum logic [2:0] {IDLE, REQ, RESP, ERR, DRAIN} arb_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
    localparam int unsigned MAX_REQ   = 8;

    // Returns {found, index}: first set bit of valid[n-1:0] at or after ptr, searching cyclically.
    function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                           input int unsigned n);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = 3'((32'(ptr) + i) % n);
            if (i < n && !res[3] && valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_mmio_arb_rr_arbiter.sv
// rtl/uart_mmio_arb_rr_arbiter.sv - combinational rotate-priority pick for the UART MMIO arbiter
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index,
    output logic [N-1:0]  onehot
);

    logic [3:0] pick;

    always_comb begin
        pick   = rr_pick(8'(valid), 3'(ptr), N);
        found  = pick[3];
        index  = IW'(pick[2:0]);
        onehot = found ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/uart_mmio_arb.sv
// rtl/uart_mmio_arb.sv - round-robin arbiter sharing the UART MMIO slave port between NUM_REQ masters
// Optional transaction watchdog with error response: UART_ARB_TIMEOUT_EN.
module uart_mmio_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*32-1:0]   i_req_addr,
    input  logic [NUM_REQ*32-1:0]   i_req_wdata,
    input  logic [NUM_REQ*4-1:0]    i_req_wmask,
    output logic [NUM_REQ-1:0]      o_resp_valid,
    output logic [31:0]             o_resp_rdata,
    input  logic [NUM_REQ-1:0]      i_resp_ready,
    output logic                    o_m_req_valid,
    input  logic                    i_m_req_ready,
    output logic [31:0]             o_m_req_addr,
    output logic [31:0]             o_m_req_wdata,
    output logic [3:0]              o_m_req_wmask,
    input  logic                    i_m_resp_valid,
    input  logic [31:0]             i_m_resp_rdata,
    output logic                    o_m_resp_ready
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_mmio_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    arb_state_e          state, state_nxt;
    logic [IW-1:0]       rr_ptr, grant, ptr_next;
    logic [31:0]         lat_addr, lat_wdata;
    logic [3:0]          lat_wmask;
    logic                pick_found, adv_ptr, tmo_hit;
    logic [IW-1:0]       pick_idx;
    logic [NUM_REQ-1:0]  pick_onehot, grant_onehot;

    rr_arbiter #(.N(NUM_REQ)) u_pick (
        .valid  (i_req_valid),
        .ptr    (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx),
        .onehot (pick_onehot)
    );

    assign grant_onehot = NUM_REQ'(1) << grant;
    assign ptr_next     = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);

    // Slave read data is decoded from the address, so the latched fields drive the slave continuously.
    assign o_m_req_addr  = lat_addr;
    assign o_m_req_wdata = lat_wdata;
    assign o_m_req_wmask = lat_wmask;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] tmo_cnt;
    logic          accepted;

    assign tmo_hit = (state == REQ || state == RESP) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Saturates at the limit so a late slave accept still falls into ERR instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt  <= '0;
            accepted <= 1'b0;
        end else if (state == IDLE) begin
            tmo_cnt  <= '0;
            accepted <= 1'b0;
        end else if (state == REQ || state == RESP) begin
            if (!tmo_hit) tmo_cnt <= tmo_cnt + CW'(1);
            if (state == REQ && i_m_req_ready) accepted <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        adv_ptr        = 1'b0;
        o_req_ready    = '0;
        o_m_req_valid  = 1'b0;
        o_resp_valid   = '0;
        o_resp_rdata   = '0;
        o_m_resp_ready = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = pick_onehot & {NUM_REQ{i_rst_n}};
                if (pick_found) state_nxt = REQ;
            end
            REQ: begin
                o_m_req_valid = 1'b1;
                if (i_m_req_ready) state_nxt = RESP;
                else if (tmo_hit)  state_nxt = ERR;
            end
            RESP: begin
                o_resp_valid   = i_m_resp_valid ? grant_onehot : '0;
                o_resp_rdata   = i_m_resp_rdata;
                o_m_resp_ready = i_resp_ready[grant];
                if (i_m_resp_valid && i_resp_ready[grant]) begin
                    adv_ptr   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                end
            end
`ifdef UART_ARB_TIMEOUT_EN
            ERR: begin
                o_resp_valid = grant_onehot;
                o_resp_rdata = ERR_RDATA;
                if (i_resp_ready[grant]) begin
                    adv_ptr   = 1'b1;
                    state_nxt = accepted ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                o_m_resp_ready = 1'b1;
                if (i_m_resp_valid) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                grant     <= pick_idx;
                lat_addr  <= i_req_addr[32*pick_idx +: 32];
                lat_wdata <= i_req_wdata[32*pick_idx +: 32];
                lat_wmask <= i_req_wmask[4*pick_idx +: 4];
            end
            if (adv_ptr) rr_ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_uart_mmio_arb.sv
// tb/tb_uart_mmio_arb.sv - self-checking bench for uart_mmio_arb with a transaction-level arbiter model
module tb_uart_mmio_arb;

    localparam int N   = 4;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    i_req_valid, o_req_ready, o_resp_valid, i_resp_ready;
    logic [N*32-1:0] i_req_addr, i_req_wdata;
    logic [N*4-1:0]  i_req_wmask;
    logic [31:0]     o_resp_rdata, o_m_req_addr, o_m_req_wdata, i_m_resp_rdata;
    logic [3:0]      o_m_req_wmask;
    logic            o_m_req_valid, i_m_req_ready, i_m_resp_valid, o_m_resp_ready;

    always #5 clk = ~clk;

    uart_mmio_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wmask(i_req_wmask),
        .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .i_resp_ready(i_resp_ready),
        .o_m_req_valid(o_m_req_valid), .i_m_req_ready(i_m_req_ready),
        .o_m_req_addr(o_m_req_addr), .o_m_req_wdata(o_m_req_wdata), .o_m_req_wmask(o_m_req_wmask),
        .i_m_resp_valid(i_m_resp_valid), .i_m_resp_rdata(i_m_resp_rdata), .o_m_resp_ready(o_m_resp_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    // Master request sources and slave behaviour knobs, set by the sequencer.
    int          m_cnt[N];
    logic [31:0] nq_addr[N], nq_wdata[N];
    logic [3:0]  nq_wmask[N];
    int          hold_cnt[N];
    bit          s_stall = 1'b0;
    int          s_delay = 0;
    bit          s_pend  = 1'b0;
    int          s_cnt   = 0;
    logic [31:0] s_addr  = '0;

    initial begin : drv
        logic [N-1:0] acc, rv;
        bit           sreq, sresp;
        logic [31:0]  a_cap;
        for (int k = 0; k < N; k++) begin m_cnt[k] = 0; hold_cnt[k] = 0; end
        i_req_valid = '0; i_req_addr = '0; i_req_wdata = '0; i_req_wmask = '0;
        i_resp_ready = '1; i_m_req_ready = 1'b0; i_m_resp_valid = 1'b0; i_m_resp_rdata = '0;
        forever begin
            @(negedge clk);
            acc   = o_req_ready & i_req_valid;
            rv    = o_resp_valid;
            sreq  = o_m_req_valid && i_m_req_ready;
            sresp = i_m_resp_valid && o_m_resp_ready;
            a_cap = o_m_req_addr;
            @(posedge clk); #1;
            if (!rst_n) begin
                i_req_valid = '0; i_m_resp_valid = 1'b0; s_pend = 1'b0; i_resp_ready = '1;
                for (int k = 0; k < N; k++) begin m_cnt[k] = 0; hold_cnt[k] = 0; end
                continue;
            end
            for (int k = 0; k < N; k++) begin
                if (acc[k]) i_req_valid[k] = 1'b0;
                if (!i_req_valid[k] && m_cnt[k] > 0) begin
                    m_cnt[k]--;
                    i_req_valid[k]        = 1'b1;
                    i_req_addr[32*k +: 32]  = nq_addr[k];
                    i_req_wdata[32*k +: 32] = nq_wdata[k];
                    i_req_wmask[4*k +: 4]   = nq_wmask[k];
                end
                if (rv[k] && hold_cnt[k] > 0) hold_cnt[k]--;
                i_resp_ready[k] = (hold_cnt[k] == 0);
            end
            if (sresp) begin s_pend = 1'b0; i_m_resp_valid = 1'b0; end
            if (sreq)  begin s_pend = 1'b1; s_cnt = s_delay; s_addr = a_cap; end
            if (s_pend && !i_m_resp_valid) begin
                if (s_cnt == 0) begin
                    i_m_resp_valid = 1'b1;
                    i_m_resp_rdata = slave_data(s_addr);
                end else begin
                    s_cnt--;
                end
            end
            i_m_req_ready = !s_stall;
        end
    end

    // Transaction-level model: one transaction at a time, winner by cyclic scan from the pointer.
    typedef enum {P_IDLE, P_REQ, P_RESP, P_ERR} phase_t;
    phase_t      ph = P_IDLE;
    int          mptr = 0, mgrant = 0, mcnt = 0, cyc = 0, grant_cyc = 0, err_cyc = 0;
    logic [31:0] maddr, mwdata, last_wdata;
    logic [3:0]  mwmask;
    int          grant_log[$];
    logic [31:0] rdata_log[$];
    int          req_pulses = 0;

    task automatic tick_timeout();
`ifdef UART_ARB_TIMEOUT_EN
        if (mcnt >= TMO - 1) begin ph = P_ERR; err_cyc = cyc + 1; end
        else mcnt++;
`endif
    endtask

    initial begin : cmp
        int           w;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("rst_req_ready", 32'(o_req_ready), 32'h0);
                check("rst_resp_valid", 32'(o_resp_valid), 32'h0);
                check("rst_m_req_valid", 32'(o_m_req_valid), 32'h0);
                check("rst_m_resp_ready", 32'(o_m_resp_ready), 32'h0);
                check("rst_m_req_addr", o_m_req_addr, 32'h0);
                check("rst_resp_rdata", o_resp_rdata, 32'h0);
                ph = P_IDLE; mptr = 0;
                continue;
            end
            if (o_m_req_valid) begin req_pulses++; last_wdata = o_m_req_wdata; end
            case (ph)
                P_IDLE: begin
                    w  = model_pick(i_req_valid, mptr);
                    oh = '0;
                    if (w >= 0) oh[w] = 1'b1;
                    check("req_ready", 32'(o_req_ready), 32'(oh));
                    check("idle_m_req_valid", 32'(o_m_req_valid), 32'h0);
                    check("idle_resp_valid", 32'(o_resp_valid), 32'h0);
                    check("idle_m_resp_ready", 32'(o_m_resp_ready), 32'h0);
                    if (w >= 0) begin
                        mgrant = w; mcnt = 0; grant_cyc = cyc;
                        maddr  = i_req_addr[32*w +: 32];
                        mwdata = i_req_wdata[32*w +: 32];
                        mwmask = i_req_wmask[4*w +: 4];
                        ph = P_REQ;
                    end
                end
                P_REQ: begin
                    check("req_req_ready", 32'(o_req_ready), 32'h0);
                    check("req_m_req_valid", 32'(o_m_req_valid), 32'h1);
                    check("req_addr", o_m_req_addr, maddr);
                    check("req_wdata", o_m_req_wdata, mwdata);
                    check("req_wmask", 32'(o_m_req_wmask), 32'(mwmask));
                    check("req_resp_valid", 32'(o_resp_valid), 32'h0);
                    if (i_m_req_ready) ph = P_RESP;
                    else tick_timeout();
                end
                P_RESP: begin
                    oh = '0;
                    if (i_m_resp_valid) oh[mgrant] = 1'b1;
                    check("resp_req_ready", 32'(o_req_ready), 32'h0);
                    check("resp_m_req_valid", 32'(o_m_req_valid), 32'h0);
                    check("resp_addr_held", o_m_req_addr, maddr);
                    check("resp_valid_route", 32'(o_resp_valid), 32'(oh));
                    check("resp_m_resp_ready", 32'(o_m_resp_ready), 32'(i_resp_ready[mgrant]));
                    if (i_m_resp_valid) check("resp_rdata", o_resp_rdata, slave_data(maddr));
                    if (i_m_resp_valid && i_resp_ready[mgrant]) begin
                        grant_log.push_back(mgrant);
                        rdata_log.push_back(o_resp_rdata);
                        mptr = (mgrant + 1) % N;
                        ph = P_IDLE;
                    end else begin
                        tick_timeout();
                    end
                end
                default: begin
                    oh = '0;
                    oh[mgrant] = 1'b1;
                    check("err_resp_valid", 32'(o_resp_valid), 32'(oh));
                    check("err_rdata", o_resp_rdata, 32'hDEAD_BEEF);
                    check("err_m_req_valid", 32'(o_m_req_valid), 32'h0);
                    if (i_resp_ready[mgrant]) begin
                        grant_log.push_back(mgrant);
                        rdata_log.push_back(o_resp_rdata);
                        mptr = (mgrant + 1) % N;
                        ph = P_IDLE;
                    end
                end
            endcase
        end
    end

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input int cnt);
        nq_addr[k] = a; nq_wdata[k] = d; nq_wmask[k] = m; m_cnt[k] = cnt;
    endtask

    task automatic wait_log(input int n, input string name);
        int c = 0;
        while (grant_log.size() < n && c < 600) begin @(posedge clk); c++; end
        n_checks++;
        if (grant_log.size() < n) begin
            n_fail++;
            $display("FAIL %s: %0d transactions completed, required %0d", name, grant_log.size(), n);
        end
        @(posedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : seq
        int base;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Masters 0 and 2 arrive together after reset.
        base = grant_log.size();
        push(0, 32'h3000_0010, 32'h0, 4'h0, 1);
        push(2, 32'h3000_0020, 32'h0, 4'h0, 1);
        wait_log(base + 2, "t1_done");
        check("t1_first", 32'(grant_log[base]), 32'd0);
        check("t1_second", 32'(grant_log[base + 1]), 32'd2);
        check("t1_ptr", 32'(mptr), 32'd3);

        // All four once from pointer 3.
        base = grant_log.size();
        for (int k = 0; k < N; k++) push(k, 32'h3000_0040 + 32'(k * 4), 32'h0, 4'h0, 1);
        wait_log(base + 4, "t1b_done");
        for (int i = 0; i < N; i++) check("t1b_order", 32'(grant_log[base + i]), 32'((3 + i) % N));

        // Master 1 writes 0x41.
        base = grant_log.size();
        req_pulses = 0;
        push(1, 32'h3000_0000, 32'h0000_0041, 4'hF, 1);
        wait_log(base + 1, "t2_done");
        check("t2_req_pulses", 32'(req_pulses), 32'd1);
        check("t2_wdata", last_wdata, 32'h0000_0041);
        check("t2_grant", 32'(grant_log[base]), 32'd1);

        // Master 3 reads with a slow slave and a slow master.
        base = grant_log.size();
        s_delay = 5;
        hold_cnt[3] = 2;
        push(3, 32'h3000_0004, 32'h0, 4'h0, 1);
        wait_log(base + 1, "t3_done");
        check("t3_grant", 32'(grant_log[base]), 32'd3);
        check("t3_rdata", rdata_log[base], 32'h95A5_0004);
        s_delay = 0;

        // All masters valid continuously for 12 transactions.
        base = grant_log.size();
        for (int k = 0; k < N; k++) push(k, 32'h3000_0100 + 32'(k * 4), 32'(k), 4'h1, 3);
        wait_log(base + 12, "t4_done");
        for (int i = 0; i < 12; i++) check("t4_order", 32'(grant_log[base + i]), 32'(i % N));

        // Reset during RESP of master 2, after master 1 moved the pointer to 2.
        base = grant_log.size();
        push(1, 32'h3000_0200, 32'h0, 4'h0, 1);
        wait_log(base + 1, "t5_pre");
        s_delay = 20;
        push(2, 32'h3000_0204, 32'h0, 4'h0, 1);
        for (int c = 0; c < 50 && ph != P_RESP; c++) @(posedge clk);
        check("t5_in_resp", 32'(ph == P_RESP), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        base = grant_log.size();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        s_delay = 0;
        check("t5_no_resp", 32'(grant_log.size()), 32'(base));
        @(negedge clk);
        for (int k = 0; k < N; k++) push(k, 32'h3000_0300 + 32'(k * 4), 32'h0, 4'h0, 1);
        wait_log(base + 4, "t5_done");
        check("t5_first_after_reset", 32'(grant_log[base]), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        // Slave never accepts: master 1 gets the error word, then master 2 is served normally.
        base = grant_log.size();
        s_stall = 1'b1;
        push(1, 32'h3000_0400, 32'h0, 4'h0, 1);
        wait_log(base + 1, "t6_err");
        check("t6_err_rdata", rdata_log[base], 32'hDEAD_BEEF);
        check("t6_req_cycles", 32'(err_cyc - grant_cyc - 1), 32'd64);
        s_stall = 1'b0;
        push(2, 32'h3000_0404, 32'h0, 4'h0, 1);
        wait_log(base + 2, "t6_next");
        check("t6_next_grant", 32'(grant_log[base + 1]), 32'd2);
        check("t6_next_rdata", rdata_log[base + 1], 32'h95A5_0404);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
